// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 3x3 convolution sequencer.
package conv_pkg;

    localparam int CONV_K_H      = 3;
    localparam int CONV_K_W      = 3;
    localparam int CONV_IN_DW    = 9;
    localparam int CONV_OUT_DW   = 8;
    localparam int CONV_W_DW     = 8;
    localparam int CONV_ACC_W    = 25;
    localparam int CONV_W_ADDR_W = 4;
    localparam int CONV_RD_CNT_W = $clog2(CONV_K_H * CONV_K_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_FILL   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_EMIT   = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    // States that run an SRAM read phase driven by the shared rd counter.
    function automatic logic is_rd_state(input state_e s);
        return (s == ST_LOAD_W) || (s == ST_FILL) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/conv_unit.sv
// Combinational 3x3 multiply-accumulate with optional ReLU; result is the
// low OUT_DATA_WIDTH bits of the signed accumulator.
module conv_unit
    import conv_pkg::*;
#(
    parameter int K_H            = CONV_K_H,
    parameter int K_W            = CONV_K_W,
    parameter int IN_DATA_WIDTH  = CONV_IN_DW,
    parameter int W_DATA_WIDTH   = CONV_W_DW,
    parameter int OUT_DATA_WIDTH = CONV_OUT_DW,
    parameter int ACC_WIDTH      = CONV_ACC_W
) (
    input  logic [K_H-1:0][K_W-1:0][IN_DATA_WIDTH-1:0] win_i,
    input  logic [K_H-1:0][K_W-1:0][W_DATA_WIDTH-1:0]  wgt_i,
    input  logic                                       relu_i,
    output logic [OUT_DATA_WIDTH-1:0]                  data_o
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] pix_x;
    logic signed [ACC_WIDTH-1:0] wgt_x;
    logic                        acc_unused;

    always_comb begin
        acc   = '0;
        pix_x = '0;
        wgt_x = '0;
        for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W; c++) begin
                pix_x = {{(ACC_WIDTH-IN_DATA_WIDTH){win_i[r][c][IN_DATA_WIDTH-1]}}, win_i[r][c]};
                wgt_x = {{(ACC_WIDTH-W_DATA_WIDTH){wgt_i[r][c][W_DATA_WIDTH-1]}}, wgt_i[r][c]};
                acc   = acc + pix_x * wgt_x;
            end
        end
    end

    assign data_o     = (relu_i && acc[ACC_WIDTH-1]) ? '0 : acc[OUT_DATA_WIDTH-1:0];
    // Middle accumulator bits only matter for the sign, which is taken from the MSB.
    assign acc_unused = ^acc[ACC_WIDTH-2:OUT_DATA_WIDTH];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for one 3x3 stride-1 convolution layer: loads weights, walks the
// input map with a column-reusing window and streams results out.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_H          = 8,
    parameter int IMG_W          = 8,
    parameter int K_H            = CONV_K_H,
    parameter int K_W            = CONV_K_W,
    parameter int IN_DATA_WIDTH  = CONV_IN_DW,
    parameter int OUT_DATA_WIDTH = CONV_OUT_DW,
    parameter int ADDR_W         = $clog2(IMG_H * IMG_W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      en_relu,
    output logic                      busy,
    output logic                      done,
    output logic                      w_rd_en,
    output logic [CONV_W_ADDR_W-1:0]  w_addr,
    input  logic [CONV_W_DW-1:0]      w_rdata,
    output logic                      in_rd_en,
    output logic [ADDR_W-1:0]         in_addr,
    input  logic [IN_DATA_WIDTH-1:0]  in_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_DATA_WIDTH-1:0] out_data,
    output logic [ADDR_W-1:0]         out_addr
);

    localparam int OUT_W  = IMG_W - K_W + 1;
    localparam int OUT_H  = IMG_H - K_H + 1;
    localparam int N_TAPS = K_H * K_W;
    localparam int OX_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OY_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    state_e                                    state_q, state_d;
    logic [CONV_RD_CNT_W-1:0]                  rd_cnt_q, rd_cnt_d;
    logic [OX_W-1:0]                           ox_q, ox_d;
    logic [OY_W-1:0]                           oy_q, oy_d;
    logic                                      relu_q, relu_d;
    logic [K_H-1:0][K_W-1:0][IN_DATA_WIDTH-1:0] win_q, win_d;
    logic [K_H-1:0][K_W-1:0][CONV_W_DW-1:0]     wgt_q, wgt_d;

    int                        rd_idx;
    int                        cap_idx;
    int                        n_reads;
    logic                      rd_issue;
    logic                      rd_capture;
    logic                      rd_last;
    logic [ADDR_W-1:0]         fill_addr;
    logic [ADDR_W-1:0]         shift_addr;
    logic [OUT_DATA_WIDTH-1:0] conv_out;

    // Read phase of N reads spans N+1 cycles: issue index k at count k,
    // capture index k-1 at count k (SRAM data lags the strobe by one cycle).
    assign rd_idx     = int'(rd_cnt_q);
    assign cap_idx    = rd_idx - 1;
    assign n_reads    = (state_q == ST_SHIFT) ? K_H : N_TAPS;
    assign rd_issue   = is_rd_state(state_q) && (rd_idx < n_reads);
    assign rd_capture = is_rd_state(state_q) && (rd_idx != 0);
    assign rd_last    = is_rd_state(state_q) && (rd_idx == n_reads);

    // FILL walks the window column-major; SHIFT fetches the new right column.
    assign fill_addr  = ADDR_W'((int'(oy_q) + rd_idx % K_H) * IMG_W + rd_idx / K_H);
    assign shift_addr = ADDR_W'((int'(oy_q) + rd_idx) * IMG_W + int'(ox_q) + K_W - 1);

    conv_unit #(
        .K_H           (K_H),
        .K_W           (K_W),
        .IN_DATA_WIDTH (IN_DATA_WIDTH),
        .W_DATA_WIDTH  (CONV_W_DW),
        .OUT_DATA_WIDTH(OUT_DATA_WIDTH),
        .ACC_WIDTH     (CONV_ACC_W)
    ) u_conv (
        .win_i (win_q),
        .wgt_i (wgt_q),
        .relu_i(relu_q),
        .data_o(conv_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            relu_q   <= 1'b0;
            win_q    <= '0;
            wgt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            relu_q   <= relu_d;
            win_q    <= win_d;
            wgt_q    <= wgt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        relu_d   = relu_q;
        win_d    = win_q;
        wgt_d    = wgt_q;

        if (is_rd_state(state_q)) begin
            rd_cnt_d = rd_last ? '0 : rd_cnt_q + CONV_RD_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD_W;
                    rd_cnt_d = '0;
                    ox_d     = '0;
                    oy_d     = '0;
                    relu_d   = en_relu;
                end
            end
            ST_LOAD_W: begin
                for (int r = 0; r < K_H; r++) begin
                    for (int c = 0; c < K_W; c++) begin
                        if (rd_capture && (r * K_W + c == cap_idx)) wgt_d[r][c] = w_rdata;
                    end
                end
                if (rd_last) state_d = ST_FILL;
            end
            ST_FILL: begin
                for (int r = 0; r < K_H; r++) begin
                    for (int c = 0; c < K_W; c++) begin
                        if (rd_capture && (c * K_H + r == cap_idx)) win_d[r][c] = in_rdata;
                    end
                end
                if (rd_last) state_d = ST_EMIT;
            end
            ST_SHIFT: begin
                for (int r = 0; r < K_H; r++) begin
                    if (rd_capture && (r == cap_idx)) begin
                        for (int c = 0; c < K_W - 1; c++) win_d[r][c] = win_q[r][c+1];
                        win_d[r][K_W-1] = in_rdata;
                    end
                end
                if (rd_last) state_d = ST_EMIT;
            end
            // out_valid is held with stable data until out_ready; a beat moves
            // only on the cycle both are high, and valid never depends on ready.
            ST_EMIT: begin
                if (out_ready) begin
                    if (int'(ox_q) < OUT_W - 1) begin
                        ox_d    = ox_q + OX_W'(1);
                        state_d = ST_SHIFT;
                    end else if (int'(oy_q) < OUT_H - 1) begin
                        ox_d    = '0;
                        oy_d    = oy_q + OY_W'(1);
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = state_q inside {ST_LOAD_W, ST_FILL, ST_SHIFT, ST_EMIT};
        done      = (state_q == ST_FIN);
        w_rd_en   = (state_q == ST_LOAD_W) && rd_issue;
        w_addr    = '0;
        in_rd_en  = ((state_q == ST_FILL) || (state_q == ST_SHIFT)) && rd_issue;
        in_addr   = '0;
        out_valid = (state_q == ST_EMIT);
        out_data  = '0;
        out_addr  = '0;

        if (w_rd_en) w_addr = CONV_W_ADDR_W'(rd_idx);
        if (in_rd_en) in_addr = (state_q == ST_FILL) ? fill_addr : shift_addr;
        if (out_valid) begin
            out_data = conv_out;
            out_addr = ADDR_W'(int'(oy_q) * OUT_W + int'(ox_q));
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl on a 5x5 map: SRAM models, reference convolution
// feeding an expected-output queue, and scenario tasks.
module tb_conv_seq_ctrl;

    localparam int IMG_H  = 5;
    localparam int IMG_W  = 5;
    localparam int OUT_W  = 3;
    localparam int OUT_H  = 3;
    localparam int ADDR_W = 5;
    localparam int LAT    = 74;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              en_relu;
    logic              busy;
    logic              done;
    logic              w_rd_en;
    logic [3:0]        w_addr;
    logic [7:0]        w_rdata = '0;
    logic              in_rd_en;
    logic [ADDR_W-1:0] in_addr;
    logic [8:0]        in_rdata = '0;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [ADDR_W-1:0] out_addr;

    logic [8:0]        img [0:31];
    logic [7:0]        wmem [0:15];
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    conv_seq_ctrl #(
        .IMG_H(IMG_H), .IMG_W(IMG_W), .K_H(3), .K_W(3),
        .IN_DATA_WIDTH(9), .OUT_DATA_WIDTH(8), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en_relu(en_relu),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_rdata(in_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= wmem[w_addr];
        if (in_rd_en) in_rdata <= img[in_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input int oy, input int ox, input bit relu);
        int acc = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc += int'($signed(img[(oy + r) * IMG_W + ox + c])) * int'($signed(wmem[r * 3 + c]));
        if (relu && acc < 0) acc = 0;
        return 8'(acc);
    endfunction

    task automatic push_expected(input bit relu);
        for (int oy = 0; oy < OUT_H; oy++)
            for (int ox = 0; ox < OUT_W; ox++) begin
                exp_q.push_back(model(oy, ox, relu));
                exp_addr_q.push_back(ADDR_W'(oy * OUT_W + ox));
            end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) img[i] = 9'(i);
    endtask

    task automatic set_weights(input int w);
        for (int i = 0; i < 16; i++) wmem[i] = (i < 9) ? 8'(w) : 8'h00;
    endtask

    task automatic run_layer(input bit relu, input int stall_addr, input bit poke, input int exp_lat);
        int start_cyc, lat, n_out, done_cnt, stall;
        logic [7:0] hold_d, exp_d;
        logic [ADDR_W-1:0] hold_a, exp_a;
        lat = -1; n_out = 0; done_cnt = 0; stall = 0;
        hold_d = '0; hold_a = '0;
        push_expected(relu);
        @(negedge clk);
        start = 1'b1; en_relu = relu; out_ready = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; en_relu = ~relu;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        for (int g = 0; g < 600; g++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = cyc - start_cyc;
                    tests_run++;
                    if (busy !== 1'b0) begin
                        tests_failed++; $display("FAIL busy_in_fin: got %b expected 0", busy);
                    end
                end
            end else if (lat >= 0) begin
                tests_run++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL idle_after_done: busy=%b out_valid=%b expected 0/0", busy, out_valid);
                end
            end
            start = poke && ((g == 20) || (done === 1'b1));
            if (out_valid === 1'b1) begin
                if (int'(out_addr) == stall_addr && stall < 4) begin
                    tests_run++;
                    if (in_rd_en !== 1'b0) begin
                        tests_failed++; $display("FAIL stall_no_read: in_rd_en=%b expected 0", in_rd_en);
                    end
                    if (stall == 0) begin
                        hold_d = out_data; hold_a = out_addr;
                    end else begin
                        tests_run++;
                        if (out_data !== hold_d || out_addr !== hold_a) begin
                            tests_failed++;
                            $display("FAIL stall_stable: got %h@%0d expected %h@%0d", out_data, out_addr, hold_d, hold_a);
                        end
                    end
                    stall++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++; $display("FAIL extra_output: got %h@%0d expected none", out_data, out_addr);
                    end else begin
                        exp_d = exp_q.pop_front(); exp_a = exp_addr_q.pop_front();
                        if (out_data !== exp_d || out_addr !== exp_a) begin
                            tests_failed++;
                            $display("FAIL out_pixel: got %h@%0d expected %h@%0d", out_data, out_addr, exp_d, exp_a);
                        end
                        n_out++;
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
            if (lat >= 0 && cyc - start_cyc >= lat + 4) break;
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (lat != exp_lat) begin
            tests_failed++; $display("FAIL latency: got %0d expected %0d (-1 = no done)", lat, exp_lat);
        end
        tests_run++;
        if (n_out != OUT_W * OUT_H || done_cnt != 1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL layer_counts: outputs=%0d dones=%0d left=%0d expected 9/1/0", n_out, done_cnt, exp_q.size());
        end
        exp_q.delete(); exp_addr_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; en_relu = 1'b0; out_ready = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, w_rd_en, in_rd_en, out_valid, out_data, out_addr, in_addr, w_addr} !== '0) begin
            tests_failed++; $display("FAIL reset_outputs: busy=%b done=%b out_valid=%b expected all 0", busy, done, out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, w_rd_en, in_rd_en, out_valid, out_data, out_addr} !== '0) begin
            tests_failed++; $display("FAIL idle_after_reset: busy=%b out_valid=%b expected 0", busy, out_valid);
        end
    endtask

    task automatic test_ones();
        load_ramp(); set_weights(1);
        run_layer(1'b0, -1, 1'b0, LAT);
    endtask

    task automatic test_neg();
        load_ramp(); set_weights(-1);
        run_layer(1'b0, -1, 1'b0, LAT);
        run_layer(1'b1, -1, 1'b0, LAT);
    endtask

    task automatic test_center();
        load_ramp(); set_weights(0); wmem[4] = 8'd2;
        run_layer(1'b0, -1, 1'b0, LAT);
    endtask

    task automatic test_backpressure();
        load_ramp();
        for (int i = 0; i < 9; i++) wmem[i] = 8'($urandom_range(0, 255));
        run_layer(1'b0, 3, 1'b0, LAT + 4);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d;
        logic [ADDR_W-1:0] exp_a;
        bit hit;
        hit = 1'b0;
        load_ramp(); set_weights(1);
        push_expected(1'b0);
        @(negedge clk);
        start = 1'b1; en_relu = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 300; g++) begin
            if (out_valid === 1'b1) begin
                exp_d = exp_q.pop_front(); exp_a = exp_addr_q.pop_front();
                tests_run++;
                if (out_data !== exp_d || out_addr !== exp_a) begin
                    tests_failed++;
                    $display("FAIL pre_abort_pixel: got %h@%0d expected %h@%0d", out_data, out_addr, exp_d, exp_a);
                end
                if (int'(out_addr) == 3) hit = 1'b1;
            end
            @(negedge clk);
            if (hit) break;
        end
        tests_run++;
        if (!hit || in_rd_en !== 1'b1 || in_addr !== ADDR_W'(8)) begin
            tests_failed++;
            $display("FAIL shift_probe: reached=%b in_rd_en=%b in_addr=%0d expected 1/1/8", hit, in_rd_en, in_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, w_rd_en, in_rd_en, out_valid, out_data, out_addr, in_addr, w_addr} !== '0) begin
            tests_failed++; $display("FAIL abort_outputs: busy=%b in_rd_en=%b in_addr=%0d expected 0", busy, in_rd_en, in_addr);
        end
        exp_q.delete(); exp_addr_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL idle_after_abort: busy=%b done=%b expected 0", busy, done);
            end
        end
        set_weights(0); wmem[4] = 8'd2; wmem[0] = 8'hFF;
        run_layer(1'b0, -1, 1'b0, LAT);
    endtask

    task automatic test_start_ignored();
        load_ramp(); set_weights(1); wmem[8] = 8'd3;
        run_layer(1'b0, -1, 1'b1, LAT);
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 32; i++) img[i] = 9'($urandom_range(0, 511));
            for (int i = 0; i < 9; i++) wmem[i] = 8'($urandom_range(0, 255));
            run_layer(1'($urandom_range(0, 1)), -1, 1'b0, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_neg();
        test_center();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
